// File: rtl/csa_acc_pkg.sv
// Shared types and width helpers for the serial carry-save accumulator.
package csa_acc_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  // Ceiling log2; returns at least 1 so counters never collapse to zero width.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Result width that holds n_ops * (2^op_w - 1) without overflow.
  function automatic int sum_width(input int op_w, input int n_ops);
    return op_w + clog2(n_ops);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder: sum is the 3-input xor, carry is the majority.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand adder: carry-save accumulation, then carry-propagate resolve.
// Build option CSA_ACC_FAST_CPA_EN: single-cycle full-width resolve instead of bit-serial.
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int OP_W  = 7,
  parameter int N_OPS = 8,
  localparam int SUM_W = sum_width(OP_W, N_OPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             busy
);

  localparam int CNT_W = clog2(N_OPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_OPS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [SUM_W-1:0] s_q, c_q;
  logic [SUM_W-1:0] out_sum_q;
  logic [SUM_W-1:0] x;
  logic [SUM_W-1:0] csa_s, csa_co, csa_c;
  logic             unused_co;

  assign x = {{(SUM_W - OP_W){1'b0}}, in_data};

  // Carry-save row: one full-adder delay per accepted operand.
  for (genvar i = 0; i < SUM_W; i++) begin : g_csa
    full_adder_cell u_fa (
      .a  (s_q[i]),
      .b  (c_q[i]),
      .ci (x[i]),
      .s  (csa_s[i]),
      .co (csa_co[i])
    );
  end

  // The top carry is mod-2^SUM_W overflow, which the width rule makes impossible.
  assign csa_c     = {csa_co[SUM_W-2:0], 1'b0};
  assign unused_co = csa_co[SUM_W-1];

`ifndef CSA_ACC_FAST_CPA_EN
  localparam int IDX_W = clog2(SUM_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SUM_W - 1);

  logic [IDX_W-1:0] idx_q;
  logic             cy_q;
  logic             rs, rco;

  full_adder_cell u_fa_resolve (
    .a  (s_q[idx_q]),
    .b  (c_q[idx_q]),
    .ci (cy_q),
    .s  (rs),
    .co (rco)
  );
`endif

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        in_ready = ~clear;
        if (in_valid && !clear && cnt_q == CNT_LAST) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
`ifdef CSA_ACC_FAST_CPA_EN
        state_d = ST_OUT;
`else
        if (idx_q == IDX_LAST) state_d = ST_OUT;
`endif
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
    busy = (state_q != ST_ACCUM) || (cnt_q != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      cnt_q     <= '0;
      s_q       <= '0;
      c_q       <= '0;
      out_sum_q <= '0;
`ifndef CSA_ACC_FAST_CPA_EN
      idx_q     <= '0;
      cy_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_ACCUM: begin
          if (clear) begin
            s_q   <= '0;
            c_q   <= '0;
            cnt_q <= '0;
          end else if (in_valid) begin
            s_q   <= csa_s;
            c_q   <= csa_c;
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
          end
        end
        ST_RESOLVE: begin
`ifdef CSA_ACC_FAST_CPA_EN
          out_sum_q <= s_q + c_q;
`else
          out_sum_q[idx_q] <= rs;
          cy_q             <= rco;
          idx_q            <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
`endif
        end
        ST_OUT: begin
          if (out_ready) begin
            s_q  <= '0;
            c_q  <= '0;
`ifndef CSA_ACC_FAST_CPA_EN
            cy_q <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum = out_sum_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Randomized self-checking bench for csa_accumulator against an integer-sum model.
module tb_csa_accumulator;

  localparam int OP_W  = 7;
  localparam int N_OPS = 8;
  localparam int SUM_W = 10;
`ifdef CSA_ACC_FAST_CPA_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = SUM_W;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OP_W-1:0]  in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [SUM_W-1:0] out_sum;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: sum of operands accepted since the last result, clear or reset.
  int acc = 0;
  int nacc = 0;
  int expected = 0;

  csa_accumulator #(.OP_W(OP_W), .N_OPS(N_OPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one operand after `gap` idle cycles; accepted at the next rising edge.
  task automatic put(input int d, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = OP_W'($urandom);
      #1;
      chk_eq("busy_gap", busy, (nacc != 0));
      @(negedge clk);
    end
    clear    = 1'b0;
    in_valid = 1'b1;
    in_data  = OP_W'(d);
    #1;
    chk_eq("in_ready_accum", in_ready, 1);
    @(posedge clk);
    acc  = acc + d;
    nacc = nacc + 1;
    if (nacc == N_OPS) begin
      expected = acc;
      acc  = 0;
      nacc = 0;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = OP_W'(50);
    #1;
    chk_eq("in_ready_clear", in_ready, 0);
    @(posedge clk);
    acc  = 0;
    nacc = 0;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_eq("busy_after_clear", busy, 0);
  endtask

  // Called right after the last operand's acceptance; offers junk operands meanwhile.
  task automatic wait_result(input int hold);
    int lat;
    lat       = 0;
    in_valid  = 1'b1;
    in_data   = OP_W'($urandom);
    out_ready = (hold == 0);
    #1;
    while (out_valid !== 1'b1 && lat < 64) begin
      chk_eq("in_ready_resolve", in_ready, 0);
      chk_eq("busy_resolve", busy, 1);
      @(negedge clk);
      lat++;
      in_data = OP_W'($urandom);
      #1;
    end
    chk_eq("latency", lat, EXP_LAT);
    chk_eq("out_sum", 32'(out_sum), expected);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk_eq("out_valid_hold", out_valid, 1);
      chk_eq("out_sum_hold", 32'(out_sum), expected);
      chk_eq("in_ready_out", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk_eq("out_valid_after", out_valid, 0);
    chk_eq("in_ready_after", in_ready, 1);
    chk_eq("busy_after", busy, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #5;
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_in_ready", in_ready, 1);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_out_sum", 32'(out_sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Maximum operands back-to-back with the consumer always ready.
    for (int k = 0; k < N_OPS; k++) put(127, 0);
    chk_eq("model_max", expected, 1016);
    wait_result(0);

    // Ascending operands separated by idle cycles.
    for (int k = 1; k <= N_OPS; k++) put(k, $urandom_range(1, 3));
    chk_eq("model_seq", expected, 36);
    wait_result(0);

    // Consumer stalls six cycles in OUT.
    for (int k = 0; k < N_OPS; k++) put(5, 0);
    wait_result(6);

    // Clear after three operands discards them and the coincident 50.
    for (int k = 0; k < 3; k++) put(100, 0);
    do_clear();
    for (int k = 0; k < N_OPS; k++) put(0, 0);
    chk_eq("model_clear", expected, 0);
    wait_result(0);

    // Asynchronous reset while the result is being resolved.
    for (int k = 0; k < N_OPS; k++) put($urandom_range(0, 127), 0);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("midrst_out_valid", out_valid, 0);
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_in_ready", in_ready, 1);
    chk_eq("midrst_out_sum", 32'(out_sum), 0);
    acc  = 0;
    nacc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N_OPS; k++) put(1, 0);
    chk_eq("model_after_rst", expected, 8);
    wait_result(0);

    // Random groups with random gaps, stalls and occasional mid-group clears.
    for (int grp = 0; grp < 24; grp++) begin
      int clear_at;
      clear_at = $urandom_range(0, 15);
      if (clear_at > 0 && clear_at < N_OPS) begin
        for (int k = 0; k < clear_at; k++) put($urandom_range(0, 127), $urandom_range(0, 1));
        do_clear();
      end
      for (int k = 0; k < N_OPS; k++) begin
        int d;
        d = ($urandom_range(0, 3) == 0) ? 127 : $urandom_range(0, 127);
        put(d, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      end
      wait_result($urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
